// File: rtl/game_pkg.sv
// Shared types and widths for the piano-game tempo logic.
// Contents: tempo_state_t FSM encoding, level/step/divider widths,
// LEVEL_MAX, and tempo_period() helper (period = base >> level).
package game_pkg;

  localparam int unsigned LEVEL_W    = 3;
  localparam int unsigned STEP_CNT_W = 16;
  localparam int unsigned DIV_W      = 26;
  localparam int unsigned LEVEL_MAX  = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } tempo_state_t;

  // Step period in clk cycles for a given speed level.
  function automatic logic [DIV_W-1:0] tempo_period(input logic [DIV_W-1:0]   base,
                                                     input logic [LEVEL_W-1:0] lvl);
    return base >> lvl;
  endfunction

endpackage

// File: rtl/tempo_divider.sv
// Pausable, clearable terminal-count counter for the tempo scheduler.
// Ports:
//   clk, rst_n  clock / async active-low reset
//   en          count this cycle (holds when low)
//   clr         force the count to zero (overrides en, suppresses tc)
//   period      terminal count is reached when count >= period-1
//   tc          combinational terminal-count flag for this cycle
module tempo_divider
  import game_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] period,
  output logic             tc
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  // >= rather than == so a period that shrinks mid-count cannot be overrun.
  always_comb begin
    tc    = 1'b0;
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q >= (period - DIV_W'(1))) begin
        tc    = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/game_tempo_ctrl.sv
// Start/pause/stop controlled step scheduler for the piano game.
// Emits one-cycle step pulses every (BASE_DIV >> level) cycles while running.
// Optional feature macro: GAME_TEMPO_AUTO_LEVEL_EN -- when defined, level
// auto-increments (saturating at 7) every STEPS_PER_LEVEL steps.
// Ports:
//   clk, rst_n   clock / async active-low reset
//   start        pulse: (re)start from step 0 at level_init
//   pause        pulse: toggle RUN <-> PAUSE
//   game_over    pulse: return to IDLE, holding level/step_cnt as the score
//   level_init   starting level sampled on an accepted start
//   step         one-cycle tempo pulse
//   running      high in RUN
//   paused       high in PAUSE
//   level        current speed level
//   step_cnt     steps issued since last start (wraps)
module game_tempo_ctrl
  import game_pkg::*;
#(
  parameter int unsigned BASE_DIV        = 50_000_000,
  parameter int unsigned STEPS_PER_LEVEL = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  game_over,
  input  logic [LEVEL_W-1:0]    level_init,
  output logic                  step,
  output logic                  running,
  output logic                  paused,
  output logic [LEVEL_W-1:0]    level,
  output logic [STEP_CNT_W-1:0] step_cnt
);

  tempo_state_t          state_q;
  tempo_state_t          state_d;
  logic                  div_en;
  logic                  div_clr;
  logic                  div_tc;
  logic [DIV_W-1:0]      period;
  logic [LEVEL_W-1:0]    level_d;
  logic [STEP_CNT_W-1:0] step_cnt_d;
  logic [STEP_CNT_W-1:0] step_cnt_inc;

  assign period       = tempo_period(DIV_W'(BASE_DIV), level);
  assign step_cnt_inc = step_cnt + STEP_CNT_W'(1);

`ifndef GAME_TEMPO_AUTO_LEVEL_EN
  logic unused_cfg;
  assign unused_cfg = ^STEPS_PER_LEVEL;
`endif

  tempo_divider u_divider (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (div_en),
    .clr    (div_clr),
    .period (period),
    .tc     (div_tc)
  );

  // Next state, divider control, level and step counter.
  // Priority: game_over > start > pause; a cycle with game_over or start
  // never counts, so neither can coincide with a step.
  always_comb begin
    state_d    = state_q;
    div_en     = 1'b0;
    div_clr    = 1'b0;
    level_d    = level;
    step_cnt_d = step_cnt;

    if (game_over) begin
      state_d = IDLE;
      div_clr = 1'b1;
    end else if (start) begin
      state_d    = RUN;
      div_clr    = 1'b1;
      level_d    = level_init;
      step_cnt_d = '0;
    end else begin
      div_en = (state_q == RUN);
      if (pause) begin
        case (state_q)
          RUN:     state_d = PAUSE;
          PAUSE:   state_d = RUN;
          default: state_d = state_q;
        endcase
      end
    end

    if (div_tc) begin
      step_cnt_d = step_cnt_inc;
`ifdef GAME_TEMPO_AUTO_LEVEL_EN
      if ((step_cnt_inc != '0) &&
          ((step_cnt_inc % STEP_CNT_W'(STEPS_PER_LEVEL)) == '0) &&
          (level != LEVEL_W'(LEVEL_MAX))) begin
        level_d = level + LEVEL_W'(1);
      end
`endif
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      step     <= 1'b0;
      running  <= 1'b0;
      paused   <= 1'b0;
      level    <= '0;
      step_cnt <= '0;
    end else begin
      state_q  <= state_d;
      step     <= div_tc;
      running  <= (state_d == RUN);
      paused   <= (state_d == PAUSE);
      level    <= level_d;
      step_cnt <= step_cnt_d;
    end
  end

endmodule

// File: tb/tb_game_tempo_ctrl.sv
// Self-checking bench for game_tempo_ctrl with BASE_DIV = 256.
module tb_game_tempo_ctrl;

  localparam int unsigned BASE_DIV = 256;
  localparam int unsigned SPL      = 16;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        pause;
  logic        game_over;
  logic [2:0]  level_init;
  logic        step;
  logic        running;
  logic        paused;
  logic [2:0]  level;
  logic [15:0] step_cnt;

  int errors;
  int checks;

  game_tempo_ctrl #(
    .BASE_DIV        (BASE_DIV),
    .STEPS_PER_LEVEL (SPL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .pause      (pause),
    .game_over  (game_over),
    .level_init (level_init),
    .step       (step),
    .running    (running),
    .paused     (paused),
    .level      (level),
    .step_cnt   (step_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: st 0=idle 1=run 2=pause; ph = RUN cycles since last step/start.
  typedef struct {
    int st;
    int ph;
    int lvl;
    int cnt;
    bit stp;
  } model_t;

  model_t m;

  function automatic model_t model_next(model_t cur, logic s, logic p, logic g, logic [2:0] li);
    model_t n;
    n     = cur;
    n.stp = 1'b0;
    if (g) begin
      n.st = 0;
      n.ph = 0;
    end else if (s) begin
      n.st  = 1;
      n.ph  = 0;
      n.cnt = 0;
      n.lvl = int'(li);
    end else begin
      if (cur.st == 1) begin
        n.ph = cur.ph + 1;
        if (n.ph >= int'(BASE_DIV >> cur.lvl)) begin
          n.ph  = 0;
          n.stp = 1'b1;
          n.cnt = (cur.cnt + 1) % 65536;
`ifdef GAME_TEMPO_AUTO_LEVEL_EN
          if (n.cnt != 0 && (n.cnt % SPL) == 0 && n.lvl < 7) n.lvl = n.lvl + 1;
`endif
        end
      end
      if (p && cur.st == 1) n.st = 2;
      else if (p && cur.st == 2) n.st = 1;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{0, 0, 0, 0, 1'b0};
    else        m <= model_next(m, start, pause, game_over, level_init);
  end

  function automatic logic [21:0] exp_vec();
    return {m.stp, (m.st == 1), (m.st == 2), 3'(m.lvl), 16'(m.cnt)};
  endfunction

  function automatic logic [21:0] obs_vec();
    return {step, running, paused, level, step_cnt};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (obs_vec() !== 22'h0) begin
      errors++;
      $display("FAIL reset_values: got %h want %h", obs_vec(), 22'h0);
    end
    rst_n = 1'b1;
    pause = 1'b1;
    tick();
    pause = 1'b0;
    checks++;
    if (obs_vec() !== 22'h0) begin
      errors++;
      $display("FAIL pause_in_idle: got %h want %h", obs_vec(), 22'h0);
    end
  endtask

  task automatic test_level0();
    int nsteps;
    int times[3];
    level_init = 3'd0;
    start      = 1'b1;
    tick();
    start  = 1'b0;
    nsteps = 0;
    times  = '{-1, -1, -1};
    checks++;
    if (running !== 1'b1) begin
      errors++;
      $display("FAIL start_running: got %b want 1", running);
    end
    for (int i = 1; i <= 800; i++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL level0 cycle %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      if (step === 1'b1) begin
        if (nsteps < 3) times[nsteps] = i;
        nsteps++;
      end
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (times[k] != 256 * (k + 1)) begin
        errors++;
        $display("FAIL level0_step_time %0d: got %0d want %0d", k, times[k], 256 * (k + 1));
      end
    end
    checks++;
    if (step_cnt !== 16'd3) begin
      errors++;
      $display("FAIL level0_step_cnt: got %0d want 3", step_cnt);
    end
  endtask

  task automatic test_level2();
    int last;
    int seen;
    level_init = 3'd2;
    start      = 1'b1;
    tick();
    start = 1'b0;
    last  = 0;
    seen  = 0;
    for (int i = 1; i <= 300; i++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL level2 cycle %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      if (step === 1'b1) begin
        seen++;
        checks++;
        if (i - last != 64) begin
          errors++;
          $display("FAIL level2_period: got %0d want 64", i - last);
        end
        last = i;
      end
    end
    checks++;
    if (seen != 4) begin
      errors++;
      $display("FAIL level2_step_count: got %0d want 4", seen);
    end
  endtask

  task automatic test_pause_resume();
    int first;
    int paused_steps;
    level_init = 3'd0;
    start      = 1'b1;
    tick();
    start        = 1'b0;
    first        = -1;
    paused_steps = 0;
    for (int i = 1; i <= 400; i++) begin
      pause = (i == 51 || i == 151);
      tick();
      pause = 1'b0;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL pause_resume cycle %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      if (paused === 1'b1 && step === 1'b1) paused_steps++;
      if (step === 1'b1 && first < 0) first = i;
    end
    checks++;
    if (first != 256 + 100) begin
      errors++;
      $display("FAIL pause_first_step: got %0d want %0d", first, 256 + 100);
    end
    checks++;
    if (paused_steps != 0) begin
      errors++;
      $display("FAIL step_while_paused: got %0d want 0", paused_steps);
    end
  endtask

  task automatic test_priority();
    logic [1:0] want[6];
    logic [2:0] stim[6];
    // {game_over, start, pause} and expected {running, paused}
    stim = '{3'b100, 3'b011, 3'b001, 3'b011, 3'b110, 3'b110};
    want = '{2'b00,  2'b10,  2'b01,  2'b10,  2'b00,  2'b00};
    level_init = 3'd5;
    for (int k = 0; k < 6; k++) begin
      {game_over, start, pause} = stim[k];
      tick();
      {game_over, start, pause} = 3'b000;
      checks++;
      if ({running, paused} !== want[k]) begin
        errors++;
        $display("FAIL priority %0d: got %b want %b", k, {running, paused}, want[k]);
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL priority_model %0d: got %h want %h", k, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_terminal();
    level_init = 3'd3;
    start      = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 96; i++) begin
      start     = (i == 32);
      game_over = (i == 96);
      tick();
      start     = 1'b0;
      game_over = 1'b0;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL terminal cycle %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      if (i == 32) begin
        checks++;
        if ({step, running, step_cnt} !== {1'b0, 1'b1, 16'd0}) begin
          errors++;
          $display("FAIL start_at_tc: got %b/%b/%0d want 0/1/0", step, running, step_cnt);
        end
      end
    end
    checks++;
    if ({step, running, level, step_cnt} !== {1'b0, 1'b0, 3'd3, 16'd1}) begin
      errors++;
      $display("FAIL game_over_at_tc: got %b/%b/%0d/%0d want 0/0/3/1", step, running, level, step_cnt);
    end
  endtask

  task automatic test_auto_level();
    int n;
    int t16;
    int gap;
    int lvl_exp;
    int gap_exp;
`ifdef GAME_TEMPO_AUTO_LEVEL_EN
    lvl_exp = 7;
    gap_exp = 2;
`else
    lvl_exp = 6;
    gap_exp = 4;
`endif
    level_init = 3'd6;
    start      = 1'b1;
    tick();
    start = 1'b0;
    n     = 0;
    t16   = -1;
    gap   = -1;
    for (int i = 1; i <= 300 && n < 32; i++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL auto_level cycle %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      if (step === 1'b1) begin
        n++;
        if (n == 16) begin
          t16 = i;
          checks++;
          if (int'(level) != lvl_exp) begin
            errors++;
            $display("FAIL level_after_16: got %0d want %0d", level, lvl_exp);
          end
        end
        if (n == 17) gap = i - t16;
      end
    end
    checks++;
    if (gap != gap_exp) begin
      errors++;
      $display("FAIL period_after_16: got %0d want %0d", gap, gap_exp);
    end
    checks++;
    if (n != 32 || int'(level) != lvl_exp) begin
      errors++;
      $display("FAIL level_after_32: got steps %0d level %0d want 32 %0d", n, level, lvl_exp);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      start      = ($urandom % 300) == 0;
      pause      = ($urandom % 70) == 0;
      game_over  = ($urandom % 600) == 0;
      level_init = 3'($urandom_range(0, 7));
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random cycle %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    {start, pause, game_over} = 3'b000;
  endtask

  task automatic test_async_reset();
    level_init = 3'd1;
    start      = 1'b1;
    tick();
    start = 1'b0;
    repeat (200) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs_vec() !== 22'h0) begin
      errors++;
      $display("FAIL async_reset: got %h want %h", obs_vec(), 22'h0);
    end
    #1;
    rst_n = 1'b1;
    tick();
    checks++;
    if (obs_vec() !== 22'h0) begin
      errors++;
      $display("FAIL after_reset_idle: got %h want %h", obs_vec(), 22'h0);
    end
  endtask

  initial begin
    clk        = 1'b0;
    rst_n      = 1'b0;
    start      = 1'b0;
    pause      = 1'b0;
    game_over  = 1'b0;
    level_init = 3'd0;
    errors     = 0;
    checks     = 0;
    test_reset();
    test_level0();
    test_level2();
    test_pause_resume();
    test_priority();
    test_terminal();
    test_auto_level();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
